// File: rtl/xbus_initiator.sv
// rtl/xbus_initiator.sv - Xbus single-word read/write initiator with four-phase ack handshake
// Optional no-acknowledge abort enabled by defining XBUS_TIMEOUT_EN.
module xbus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic [21:0] vma,
  input  logic [31:0] wdata,
  input  logic        ack_n,
  input  logic [31:0] bus_in,
  input  logic        mempar_in,
  input  logic        ignpar,
  input  logic        clr_err,
  output logic        req,
  output logic [21:0] addr,
  output logic        wrcyc,
  output logic [31:0] bus_out,
  output logic        bus_oe,
  output logic        mempar_out,
  output logic [31:0] md,
  output logic        loadmd,
  output logic        done,
  output logic        busy,
  output logic        perr,
  output logic        nxm
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("xbus_initiator: TIMEOUT out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL} state_t;

  state_t      state_q, state_d;
  logic        req_d, wrcyc_d, bus_oe_d, mempar_d, loadmd_d, done_d, busy_d, perr_d, nxm_d;
  logic [21:0] addr_d;
  logic [31:0] bus_out_d, md_d;
`ifdef XBUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req;
    addr_d   = addr;
    wrcyc_d  = wrcyc;
    bus_out_d = bus_out;
    bus_oe_d = bus_oe;
    md_d     = md;
    loadmd_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy;
    perr_d   = perr & ~clr_err;
`ifdef XBUS_TIMEOUT_EN
    nxm_d    = nxm & ~clr_err;
    cnt_d    = cnt_q;
`else
    nxm_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // write wins when both starts arrive on the same edge
        if (start_wr || start_rd) begin
          addr_d    = vma;
          bus_out_d = wdata;
          wrcyc_d   = start_wr;
          bus_oe_d  = start_wr;
          req_d     = 1'b1;
          busy_d    = 1'b1;
          state_d   = WAIT_ACK;
`ifdef XBUS_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      WAIT_ACK: begin
`ifdef XBUS_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (!ack_n) begin
          req_d    = 1'b0;
          bus_oe_d = 1'b0;
          done_d   = 1'b1;
          state_d  = WAIT_REL;
          if (!wrcyc) begin
            md_d     = bus_in;
            loadmd_d = 1'b1;
            if (!ignpar && !(^{bus_in, mempar_in}))
              perr_d = 1'b1;
          end
        end
`ifdef XBUS_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          req_d    = 1'b0;
          bus_oe_d = 1'b0;
          done_d   = 1'b1;
          nxm_d    = 1'b1;
          state_d  = WAIT_REL;
          if (!wrcyc) begin
            md_d     = 32'hFFFF_FFFF;
            loadmd_d = 1'b1;
          end
        end
`endif
      end
      WAIT_REL: begin
        if (ack_n) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mempar_d = ~^bus_out_d;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req        <= 1'b0;
      addr       <= 22'd0;
      wrcyc      <= 1'b0;
      bus_out    <= 32'd0;
      bus_oe     <= 1'b0;
      mempar_out <= 1'b1;
      md         <= 32'd0;
      loadmd     <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      perr       <= 1'b0;
      nxm        <= 1'b0;
`ifdef XBUS_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      req        <= req_d;
      addr       <= addr_d;
      wrcyc      <= wrcyc_d;
      bus_out    <= bus_out_d;
      bus_oe     <= bus_oe_d;
      mempar_out <= mempar_d;
      md         <= md_d;
      loadmd     <= loadmd_d;
      done       <= done_d;
      busy       <= busy_d;
      perr       <= perr_d;
      nxm        <= nxm_d;
`ifdef XBUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_xbus_initiator.sv
// tb/tb_xbus_initiator.sv - randomized scoreboard bench for xbus_initiator
module tb_xbus_initiator;

  logic        mclk = 1'b0;
  logic        reset_n, start_rd, start_wr, ack_n, mempar_in, ignpar, clr_err;
  logic [21:0] vma;
  logic [31:0] wdata, bus_in;
  logic        req, wrcyc, bus_oe, mempar_out, loadmd, done, busy, perr, nxm;
  logic [21:0] addr;
  logic [31:0] bus_out, md;

  always #5 mclk = ~mclk;

  xbus_initiator #(.TIMEOUT(16)) dut (
    .mclk(mclk), .reset_n(reset_n), .start_rd(start_rd), .start_wr(start_wr),
    .vma(vma), .wdata(wdata), .ack_n(ack_n), .bus_in(bus_in), .mempar_in(mempar_in),
    .ignpar(ignpar), .clr_err(clr_err), .req(req), .addr(addr), .wrcyc(wrcyc),
    .bus_out(bus_out), .bus_oe(bus_oe), .mempar_out(mempar_out), .md(md),
    .loadmd(loadmd), .done(done), .busy(busy), .perr(perr), .nxm(nxm)
  );

  typedef struct {
    logic        rd;
    logic [21:0] a;
    logic [31:0] w;
    logic [31:0] md;
    logic        perr;
    logic        nxm;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          req_rises = 0, txns = 0;
  logic [31:0] md_m = 32'd0;
  logic        perr_m = 1'b0, nxm_m = 1'b0;
  logic        req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: check bus drive on each new request, check results on each done
  always @(negedge mclk) begin
    if (reset_n) begin
      if (req && !req_prev) begin
        req_rises++;
        if (sb.size() == 0) chk("req_without_start", 1, 0);
        else begin
          chk("addr", {10'd0, addr}, {10'd0, sb[0].a});
          chk("wrcyc", {31'd0, wrcyc}, {31'd0, !sb[0].rd});
          chk("bus_oe", {31'd0, bus_oe}, {31'd0, !sb[0].rd});
          chk("bus_out", bus_out, sb[0].w);
          chk("mempar_out", {31'd0, mempar_out}, {31'd0, ($countones(sb[0].w) % 2) == 0});
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("done_without_start", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("md", md, e.md);
          chk("loadmd", {31'd0, loadmd}, {31'd0, e.rd});
          chk("perr", {31'd0, perr}, {31'd0, e.perr});
          chk("nxm", {31'd0, nxm}, {31'd0, e.nxm});
        end
      end
    end
    req_prev = req;
  end

  // Issue a start at the current negedge and push the expected outcome
  task automatic issue(input bit rd, input bit both, input logic [21:0] a, input logic [31:0] w,
                       input logic [31:0] d, input logic p, input bit ip, input bit aborts);
    exp_t e;
    bit   is_rd;
    is_rd = rd && !both;
    vma = a; wdata = w; bus_in = d; mempar_in = p; ignpar = ip;
    start_rd = rd | both; start_wr = !rd | both;
    if (aborts) begin
      if (is_rd) md_m = 32'hFFFF_FFFF;
      nxm_m = 1'b1;
    end else if (is_rd) begin
      md_m = d;
      if (!ip && ($countones({d, p}) % 2 == 0)) perr_m = 1'b1;
    end
    e.rd = is_rd; e.a = a; e.w = w; e.md = md_m; e.perr = perr_m; e.nxm = nxm_m;
    sb.push_back(e);
    txns++;
  endtask

  task automatic do_txn(input bit rd, input bit both, input logic [21:0] a, input logic [31:0] w,
                        input logic [31:0] d, input logic p, input bit ip,
                        input int dly, input int hold, input bit extra, input bit timed);
    int k;
    issue(rd, both, a, w, d, p, ip, 1'b0);
    @(negedge mclk);
    start_rd = extra; start_wr = extra;
    chk("req_after_start", {31'd0, req}, 1);
    chk("busy_after_start", {31'd0, busy}, 1);
    for (int i = 0; i < dly; i++) begin
      @(negedge mclk);
      start_rd = 1'b0; start_wr = 1'b0;
    end
    if (dly > 50) chk("req_held_no_ack", {31'd0, req}, 1);
    ack_n = 1'b0;
    @(negedge mclk);
    if (timed) chk("done_at_e0p2", {30'd0, done, loadmd}, 2'b11);
    k = 0;
    while (req && k < 2000) begin @(negedge mclk); k++; end
    chk("req_fell", {31'd0, req}, 0);
    repeat (hold) @(negedge mclk);
    if (timed) chk("busy_before_release", {31'd0, busy}, 1);
    ack_n = 1'b1;
    k = 0;
    while (busy && k < 100) begin @(negedge mclk); k++; end
    chk("busy_released", {31'd0, busy}, 0);
    if (timed) chk("release_latency", k, 1);
  endtask

  initial begin
    reset_n = 1'b0; start_rd = 1'b0; start_wr = 1'b0; ack_n = 1'b1; clr_err = 1'b0;
    vma = '0; wdata = '0; bus_in = '0; mempar_in = 1'b0; ignpar = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst_out", {req, wrcyc, bus_oe, loadmd, done, busy, perr, nxm, mempar_out}, 9'b000000001);
    chk("rst_addr", {10'd0, addr}, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_md", md, 0);
    reset_n = 1'b1;
    @(negedge mclk);

    do_txn(1, 0, 22'o00000001, 32'h0, 32'o0011, 1'b1, 0, 1, 1, 0, 1);
    do_txn(0, 0, 22'o17377775, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 0, 1, 1, 0, 0);
    do_txn(1, 1, 22'h2AAAA, 32'hCAFE_0001, 32'h5555_0000, 1'b0, 0, 2, 0, 1, 0);
    do_txn(1, 0, 22'h00123, 32'h0, 32'h0000_0003, 1'b1, 0, 1, 2, 1, 0);
    do_txn(1, 0, 22'h00124, 32'h0, 32'h0000_0007, 1'b0, 0, 1, 0, 0, 0);
    clr_err = 1'b1; perr_m = 1'b0; nxm_m = 1'b0;
    @(negedge mclk);
    clr_err = 1'b0;
    chk("perr_cleared", {31'd0, perr}, 0);
    do_txn(1, 0, 22'h00125, 32'h0, 32'h0000_0003, 1'b1, 1, 1, 1, 0, 0);

`ifdef XBUS_TIMEOUT_EN
    begin
      int k;
      issue(1, 0, 22'h3FFFF, 32'h0, 32'h0, 1'b1, 0, 1'b1);
      @(negedge mclk);
      start_rd = 1'b0; start_wr = 1'b0;
      k = 0;
      while (req && k < 200) begin @(negedge mclk); k++; end
      chk("timeout_cycles", k, 16);
      k = 0;
      while (busy && k < 20) begin @(negedge mclk); k++; end
      chk("busy_after_abort", {31'd0, busy}, 0);
    end
`else
    do_txn(0, 0, 22'h3FFFF, 32'h0F0F_0F0F, 32'h0, 1'b0, 0, 1000, 1, 0, 0);
`endif

    issue(1, 0, 22'h01010, 32'h0, 32'h1, 1'b0, 0, 1'b0);
    @(negedge mclk);
    start_rd = 1'b0;
    @(negedge mclk);
    reset_n = 1'b0;
    @(negedge mclk);
    chk("rst_mid_req_busy", {30'd0, req, busy}, 0);
    chk("rst_mid_md", md, 0);
    reset_n = 1'b1;
    sb.delete();
    md_m = 32'd0; perr_m = 1'b0; nxm_m = 1'b0;
    req_rises--;
    txns--;
    @(negedge mclk);
    do_txn(1, 0, 22'h01011, 32'h0, 32'h8000_0001, 1'b1, 0, 1, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      do_txn($urandom_range(0, 1), ($urandom_range(0, 9) == 0), 22'($urandom), $urandom, $urandom,
             1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 4), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), 0);
      if ($urandom_range(0, 7) == 0) begin
        clr_err = 1'b1; perr_m = 1'b0; nxm_m = 1'b0;
        @(negedge mclk);
        clr_err = 1'b0;
      end
    end

    repeat (3) @(negedge mclk);
    chk("req_count", req_rises, txns);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
